// File: rtl/shift_pipe_if.sv
// Handshake bundle for shift_pipe: operation in on one side, result out on the other.
// master is the ALU-side user (producer and consumer); slave is the shifter itself.
interface shift_pipe_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_mode;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;
    logic               out_zero;

    modport master (
        output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_zero
    );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL), one registered stage per shift-amount bit.
// Stage k applies 2^(SHAMT_W-1-k); the whole pipe freezes while the output is stalled.
module shift_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 5
) (
    input  logic          clock,
    input  logic          reset,
    shift_pipe_if.slave   bus
);
    localparam int LAST = SHAMT_W - 1;

    logic               stgValid [SHAMT_W];
    logic [WIDTH-1:0]   stgData  [SHAMT_W];
    logic [1:0]         stgMode  [SHAMT_W];
    logic [TAG_W-1:0]   stgTag   [SHAMT_W];
    logic [SHAMT_W-1:0] stgShamt [SHAMT_W];

    logic               nxtValid [SHAMT_W];
    logic [WIDTH-1:0]   nxtData  [SHAMT_W];
    logic [1:0]         nxtMode  [SHAMT_W];
    logic [TAG_W-1:0]   nxtTag   [SHAMT_W];
    logic [SHAMT_W-1:0] nxtShamt [SHAMT_W];

    logic               srcValid;
    logic [WIDTH-1:0]   srcData;
    logic [1:0]         srcMode;
    logic [TAG_W-1:0]   srcTag;
    logic [SHAMT_W-1:0] srcShamt;
    logic               stall;

    // s is always in 1..WIDTH/2, so the rotate's right-shift term never reaches WIDTH
    function automatic logic [WIDTH-1:0] shiftBy(input logic [WIDTH-1:0] d,
                                                 input logic [1:0] m,
                                                 input int s);
        logic [WIDTH-1:0] r;
        case (m)
            2'b00:   r = d << s;
            2'b01:   r = d >> s;
            2'b10:   r = $signed(d) >>> s;
            default: r = (d << s) | (d >> (WIDTH - s));
        endcase
        return r;
    endfunction

    assign stall         = stgValid[LAST] && !bus.out_ready;
    assign bus.in_ready  = !stall;
    assign bus.out_valid = stgValid[LAST];
    assign bus.out_data  = stgData[LAST];
    assign bus.out_tag   = stgTag[LAST];
    assign bus.out_zero  = stgValid[LAST] && (stgData[LAST] == '0);

    always_comb begin
        srcValid = 1'b0;
        srcData  = '0;
        srcMode  = '0;
        srcTag   = '0;
        srcShamt = '0;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (k == 0) begin
                srcValid = bus.in_valid;
                srcData  = bus.in_data;
                srcMode  = bus.in_mode;
                srcTag   = bus.in_tag;
                srcShamt = bus.in_shamt;
            end else begin
                srcValid = stgValid[k-1];
                srcData  = stgData[k-1];
                srcMode  = stgMode[k-1];
                srcTag   = stgTag[k-1];
                srcShamt = stgShamt[k-1];
            end
            nxtValid[k] = srcValid;
            nxtMode[k]  = srcMode;
            nxtTag[k]   = srcTag;
            nxtShamt[k] = srcShamt;
            nxtData[k]  = srcShamt[LAST-k] ? shiftBy(srcData, srcMode, 1 << (LAST - k))
                                           : srcData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                stgValid[k] <= 1'b0;
                stgData[k]  <= '0;
                stgMode[k]  <= '0;
                stgTag[k]   <= '0;
                stgShamt[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                stgValid[k] <= nxtValid[k];
                stgData[k]  <= nxtData[k];
                stgMode[k]  <= nxtMode[k];
                stgTag[k]   <= nxtTag[k];
                stgShamt[k] <= nxtShamt[k];
            end
        end
    end
endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed vectors, stall/reset scenarios and a
// randomized stream checked against a bit-level reference model and an ordering queue.
module tb_shift_pipe;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    shift_pipe_if #(.WIDTH(32), .SHAMT_W(5), .TAG_W(5)) bus ();
    shift_pipe_if #(.WIDTH(8),  .SHAMT_W(3), .TAG_W(3)) bus8 ();

    shift_pipe #(.WIDTH(32), .SHAMT_W(5), .TAG_W(5)) dut  (.clock(clock), .reset(reset), .bus(bus));
    shift_pipe #(.WIDTH(8),  .SHAMT_W(3), .TAG_W(3)) dut8 (.clock(clock), .reset(reset), .bus(bus8));

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
    } exp_t;

    // Result bit i taken straight from the mode definitions, for a w-bit operand
    function automatic logic [31:0] refShift(input logic [31:0] d, input int s, input int m, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (m)
                0:       r[i] = (i >= s)    ? d[i-s] : 1'b0;
                1:       r[i] = (i + s < w) ? d[i+s] : 1'b0;
                2:       r[i] = (i + s < w) ? d[i+s] : d[w-1];
                default: r[i] = d[(i - s + w) % w];
            endcase
        end
        return r;
    endfunction

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_mode   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.in_data   = '0;
        bus8.in_shamt  = '0;
        bus8.in_mode   = '0;
        bus8.in_tag    = '0;
        bus8.out_ready = 1'b1;
    endtask

    task automatic drive(input logic [31:0] d, input int sh, input int m, input int t);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = 5'(sh);
        bus.in_mode  = 2'(m);
        bus.in_tag   = 5'(t);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clock);
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        vectors++; if (bus.out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
        vectors++; if (bus.out_tag !== 5'h0) begin miscompares++; $display("FAIL reset_out_tag got %h want 0", bus.out_tag); end
        vectors++; if (bus.out_zero !== 1'b0) begin miscompares++; $display("FAIL reset_out_zero got %b want 0", bus.out_zero); end
        reset = 1'b0;
        @(negedge clock);
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_out_valid got %b want 0", bus.out_valid); end
    endtask

    typedef struct {
        logic [31:0] d;
        int          sh;
        int          m;
        int          t;
        logic [31:0] e;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[11];
        int lat;
        tbl = '{
            '{32'h0000_0001, 31, 0,  7, 32'h8000_0000},
            '{32'h8000_0000, 31, 1,  8, 32'h0000_0001},
            '{32'h8000_0001,  1, 3,  9, 32'h0000_0003},
            '{32'h8000_0000,  1, 0, 10, 32'h0000_0000},
            '{32'hDEAD_BEEF,  0, 0, 11, 32'hDEAD_BEEF},
            '{32'hDEAD_BEEF,  0, 1, 12, 32'hDEAD_BEEF},
            '{32'hDEAD_BEEF,  0, 2, 13, 32'hDEAD_BEEF},
            '{32'hDEAD_BEEF,  0, 3, 14, 32'hDEAD_BEEF},
            '{32'h1234_5678,  8, 3, 15, 32'h3456_7812},
            '{32'h7FFF_FFFF, 31, 2, 16, 32'h0000_0000},
            '{32'h8000_0000, 31, 2, 17, 32'hFFFF_FFFF}
        };
        foreach (tbl[i]) begin
            @(negedge clock);
            drive(tbl[i].d, tbl[i].sh, tbl[i].m, tbl[i].t);
            bus.out_ready = 1'b1;
            @(negedge clock);
            bus.in_valid = 1'b0;
            lat = 1;
            #1;
            while (!bus.out_valid && lat < 20) begin
                @(negedge clock);
                lat++;
                #1;
            end
            vectors++; if (lat != 5) begin miscompares++; $display("FAIL directed_latency[%0d] got %0d want 5", i, lat); end
            vectors++; if (bus.out_data !== tbl[i].e) begin miscompares++; $display("FAIL directed_data[%0d] got %h want %h", i, bus.out_data, tbl[i].e); end
            vectors++; if (bus.out_tag !== 5'(tbl[i].t)) begin miscompares++; $display("FAIL directed_tag[%0d] got %0d want %0d", i, bus.out_tag, tbl[i].t); end
            vectors++; if (bus.out_zero !== (tbl[i].e == 32'h0)) begin miscompares++; $display("FAIL directed_zero[%0d] got %b want %b", i, bus.out_zero, tbl[i].e == 32'h0); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clock);
        drive(32'h8000_0000, 4, 2, 1);
        @(negedge clock);
        drive(32'h8000_0000, 4, 1, 2);
        @(negedge clock);
        bus.in_valid = 1'b0;
        lat = 2;
        #1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clock);
            lat++;
            #1;
        end
        vectors++; if (lat != 5) begin miscompares++; $display("FAIL b2b_latency got %0d want 5", lat); end
        vectors++; if (bus.out_data !== 32'hF800_0000 || bus.out_tag !== 5'd1) begin miscompares++; $display("FAIL b2b_first got %h/%0d want f8000000/1", bus.out_data, bus.out_tag); end
        @(negedge clock);
        #1;
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0800_0000 || bus.out_tag !== 5'd2) begin miscompares++; $display("FAIL b2b_second got v%b %h/%0d want v1 08000000/2", bus.out_valid, bus.out_data, bus.out_tag); end
        @(negedge clock);
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_stall();
        logic [31:0] dArr [8];
        int shArr [8];
        int mArr [8];
        int issued = 0, got = 0, held = 0;
        logic stallNow, prevStall = 1'b0;
        logic [31:0] prevData = '0;
        logic [4:0] prevTag = '0;
        logic [31:0] e;
        for (int i = 0; i < 8; i++) begin
            dArr[i]  = $urandom;
            shArr[i] = $urandom_range(0, 31);
            mArr[i]  = $urandom_range(0, 3);
        end
        for (int c = 0; c < 60 && got < 8; c++) begin
            @(negedge clock);
            if (issued < 8) drive(dArr[issued], shArr[issued], mArr[issued], issued);
            else bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            #1;
            stallNow = bus.out_valid && bus.out_tag == 5'd2 && held < 3;
            if (stallNow) begin
                bus.out_ready = 1'b0;
                held++;
            end
            #1;
            vectors++; if (bus.in_ready !== !stallNow) begin miscompares++; $display("FAIL stall_in_ready cycle %0d got %b want %b", c, bus.in_ready, !stallNow); end
            if (prevStall) begin
                vectors++; if (bus.out_valid !== 1'b1 || bus.out_tag !== prevTag || bus.out_data !== prevData) begin miscompares++; $display("FAIL stall_hold got v%b %h/%0d want v1 %h/%0d", bus.out_valid, bus.out_data, bus.out_tag, prevData, prevTag); end
            end
            if (bus.out_valid && bus.out_ready) begin
                e = refShift(dArr[got], shArr[got], mArr[got], 32);
                vectors++; if (bus.out_tag !== 5'(got) || bus.out_data !== e) begin miscompares++; $display("FAIL stall_result got %h/%0d want %h/%0d", bus.out_data, bus.out_tag, e, got); end
                got++;
            end
            if (bus.in_valid && bus.in_ready) issued++;
            prevStall = stallNow;
            prevData  = bus.out_data;
            prevTag   = bus.out_tag;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        vectors++; if (got != 8) begin miscompares++; $display("FAIL stall_delivered got %0d want 8", got); end
        vectors++; if (held != 3) begin miscompares++; $display("FAIL stall_cycles got %0d want 3", held); end
        repeat (6) begin
            @(negedge clock);
            #1;
            vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_extra_result got %b want 0", bus.out_valid); end
        end
    endtask

    task automatic test_random(input int nOps);
        exp_t q[$];
        exp_t e;
        int issued = 0, got = 0;
        logic haveOp = 1'b0;
        logic [31:0] cd = '0;
        int csh = 0, cm = 0;
        logic prevStall = 1'b0;
        logic [31:0] prevData = '0;
        logic [4:0] prevTag = '0;
        for (int c = 0; c < 3000 && got < nOps; c++) begin
            @(negedge clock);
            if (!haveOp && issued < nOps && $urandom_range(0, 3) != 0) begin
                cd  = ($urandom_range(0, 7) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'($urandom);
                csh = $urandom_range(0, 31);
                cm  = $urandom_range(0, 3);
                haveOp = 1'b1;
            end
            if (haveOp) drive(cd, csh, cm, issued % 32);
            else bus.in_valid = 1'b0;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            vectors++; if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin miscompares++; $display("FAIL rand_in_ready cycle %0d got %b want %b", c, bus.in_ready, !(bus.out_valid && !bus.out_ready)); end
            if (prevStall) begin
                vectors++; if (bus.out_valid !== 1'b1 || bus.out_tag !== prevTag || bus.out_data !== prevData) begin miscompares++; $display("FAIL rand_hold got v%b %h/%0d want v1 %h/%0d", bus.out_valid, bus.out_data, bus.out_tag, prevData, prevTag); end
            end
            if (bus.out_valid && bus.out_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++; $display("FAIL rand_unexpected got %h/%0d want no result", bus.out_data, bus.out_tag);
                end else begin
                    e = q.pop_front();
                    if (bus.out_data !== e.data || bus.out_tag !== e.tag || bus.out_zero !== (e.data == 32'h0)) begin
                        miscompares++; $display("FAIL rand_result got %h/%0d z%b want %h/%0d z%b", bus.out_data, bus.out_tag, bus.out_zero, e.data, e.tag, e.data == 32'h0);
                    end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back('{refShift(cd, csh, cm, 32), 5'(issued % 32)});
                issued++;
                haveOp = 1'b0;
            end
            prevStall = bus.out_valid && !bus.out_ready;
            prevData  = bus.out_data;
            prevTag   = bus.out_tag;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        vectors++; if (got != nOps) begin miscompares++; $display("FAIL rand_count got %0d want %0d", got, nOps); end
        vectors++; if (q.size() != 0) begin miscompares++; $display("FAIL rand_leftover got %0d want 0", q.size()); end
    endtask

    task automatic test_reset_flush();
        int lat;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            drive(32'h0000_0001 << i, 3, 0, 10 + i);
            bus.out_ready = 1'b1;
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
        repeat (8) begin
            @(negedge clock);
            #1;
            vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_stale got %h/%0d want no result", bus.out_data, bus.out_tag); end
        end
        @(negedge clock);
        drive(32'h0000_00F0, 4, 0, 21);
        @(negedge clock);
        bus.in_valid = 1'b0;
        lat = 1;
        #1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clock);
            lat++;
            #1;
        end
        vectors++; if (lat != 5) begin miscompares++; $display("FAIL flush_new_latency got %0d want 5", lat); end
        vectors++; if (bus.out_data !== 32'h0000_0F00 || bus.out_tag !== 5'd21) begin miscompares++; $display("FAIL flush_new_result got %h/%0d want 00000f00/21", bus.out_data, bus.out_tag); end
    endtask

    task automatic test_width8();
        logic [7:0] d, e;
        int sh, m, lat;
        for (int i = 0; i < 14; i++) begin
            if (i == 0) begin d = 8'h90; sh = 3; m = 2; e = 8'hF2; end
            else if (i == 1) begin d = 8'h81; sh = 7; m = 3; e = 8'hC0; end
            else begin
                d  = 8'($urandom);
                sh = $urandom_range(0, 7);
                m  = $urandom_range(0, 3);
                e  = 8'(refShift({24'h0, d}, sh, m, 8));
            end
            @(negedge clock);
            bus8.in_valid = 1'b1;
            bus8.in_data  = d;
            bus8.in_shamt = 3'(sh);
            bus8.in_mode  = 2'(m);
            bus8.in_tag   = 3'(i);
            bus8.out_ready = 1'b1;
            @(negedge clock);
            bus8.in_valid = 1'b0;
            lat = 1;
            #1;
            while (!bus8.out_valid && lat < 20) begin
                @(negedge clock);
                lat++;
                #1;
            end
            vectors++; if (lat != 3) begin miscompares++; $display("FAIL w8_latency[%0d] got %0d want 3", i, lat); end
            vectors++; if (bus8.out_data !== e || bus8.out_tag !== 3'(i)) begin miscompares++; $display("FAIL w8_result[%0d] got %h/%0d want %h/%0d", i, bus8.out_data, bus8.out_tag, e, i % 8); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_random(200);
        test_reset_flush();
        test_width8();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
